vga_cfg_seq: RTL and testbench

Parametrised Wishbone-master configuration sequencer for the vga_enh_top slave register port.
On a start pulse it writes a six-entry register program (CTRL stop, VBARA, HTIM, VTIM, HVLEN, CTRL start) for one of three resolution presets selected at run time.
It replaces a fixed, one-shot power-up initialiser. It adds run-time re-configuration, ack timeout, bounded retry on error or timeout, and done/error status.
It sits between system control logic and the DVI core slave port, in the wb_clk domain.

---
 rtl/vga_cfg_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_cfg_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_cfg_seq.sv
// Wishbone master that writes a six-register mode program into the vga_enh_top slave port.
// Optional read-back verify of registers idx 1..4 is enabled by defining VGA_CFG_READBACK_EN.
module vga_cfg_seq #(
   parameter int unsigned ADR_W       = 12,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned RETRIES     = 3,
   parameter logic [1:0]  CD          = 2'h3,
   parameter logic [1:0]  VBL         = 2'b10,
   parameter logic        PC          = 1'b0,
   parameter logic        HPOL        = 1'b1,
   parameter logic        VPOL        = 1'b1,
   parameter logic        CPOL        = 1'b0,
   parameter logic        BPOL        = 1'b0,
   parameter logic [1:0]  DVI_ODF     = 2'b00
) (
   input  logic             wb_clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode_sel,
   input  logic [31:0]      vbara_i,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [2:0]       err_idx,
   output logic [ADR_W-1:0] wbs_adr_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [31:0]      wbs_dat_i,
   output logic [3:0]       wbs_sel_o,
   output logic             wbs_we_o,
   output logic             wbs_stb_o,
   output logic             wbs_cyc_o,
   input  logic             wbs_ack_i,
   input  logic             wbs_err_i
);

   typedef enum logic [2:0] {
      StIdle, StIssue, StWait, StNext, StDone, StFail, StRdbk, StRwait
   } state_e;

   localparam logic [31:0] CTRL_WORD = {2'b00, DVI_ODF, 12'b0, BPOL, CPOL, VPOL, HPOL, PC,
                                        CD, VBL, 6'b0, 1'b1};
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

   state_e           state_q;
   logic [2:0]       idx_q;
   logic [7:0]       retry_q;
   logic [15:0]      tmo_q;
   logic [1:0]       mode_q;
   logic [31:0]      vbara_q;

   logic [31:0]      htim, vtim, hvlen;
   logic [ADR_W-1:0] prog_adr;
   logic [31:0]      prog_dat;
   logic             tmo_hit;
   logic             can_retry;

   assign wbs_sel_o = 4'b1111;
   assign tmo_hit   = (tmo_q == TMO_LAST);
   assign can_retry = (32'(retry_q) < RETRIES);

   // Timing presets: {sync, gdel, gate} horizontal/vertical and {hlen, vlen}.
   always_comb begin
      htim  = {8'd95, 8'd39, 16'd639};
      vtim  = {8'd1, 8'd24, 16'd479};
      hvlen = {16'd799, 16'd524};
      unique case (mode_q)
         2'd1: begin
            htim  = {8'd127, 8'd87, 16'd799};
            vtim  = {8'd3, 8'd22, 16'd599};
            hvlen = {16'd1055, 16'd627};
         end
         2'd2: begin
            htim  = {8'd135, 8'd159, 16'd1023};
            vtim  = {8'd5, 8'd28, 16'd767};
            hvlen = {16'd1343, 16'd805};
         end
         default: ;
      endcase
   end

   always_comb begin
      prog_adr = '0;
      prog_dat = '0;
      unique case (idx_q)
         3'd1: begin
            prog_adr = ADR_W'(8'h14);
            prog_dat = vbara_q;
         end
         3'd2: begin
            prog_adr = ADR_W'(8'h08);
            prog_dat = htim;
         end
         3'd3: begin
            prog_adr = ADR_W'(8'h0C);
            prog_dat = vtim;
         end
         3'd4: begin
            prog_adr = ADR_W'(8'h10);
            prog_dat = hvlen;
         end
         3'd5: prog_dat = CTRL_WORD;
         default: ;
      endcase
   end

`ifndef VGA_CFG_READBACK_EN
   logic unused_dat;
   assign unused_dat = ^wbs_dat_i;
`endif

   always_ff @(posedge wb_clk) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         retry_q   <= '0;
         tmo_q     <= '0;
         mode_q    <= '0;
         vbara_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         err_idx   <= '0;
         wbs_adr_o <= '0;
         wbs_dat_o <= '0;
         wbs_we_o  <= 1'b0;
         wbs_stb_o <= 1'b0;
         wbs_cyc_o <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone, StFail: begin
               if (start) begin
                  done    <= 1'b0;
                  err_idx <= '0;
                  mode_q  <= mode_sel;
                  vbara_q <= vbara_i;
                  idx_q   <= '0;
                  retry_q <= '0;
                  if (mode_sel == 2'd3) begin
                     busy    <= 1'b0;
                     error   <= 1'b1;
                     state_q <= StFail;
                  end else begin
                     busy    <= 1'b1;
                     error   <= 1'b0;
                     state_q <= StIssue;
                  end
               end
            end
            StIssue: begin
               wbs_adr_o <= prog_adr;
               wbs_dat_o <= prog_dat;
               wbs_we_o  <= 1'b1;
               wbs_stb_o <= 1'b1;
               wbs_cyc_o <= 1'b1;
               tmo_q     <= '0;
               state_q   <= StWait;
            end
            StWait: begin
               if (wbs_ack_i) begin
                  wbs_stb_o <= 1'b0;
                  wbs_cyc_o <= 1'b0;
                  wbs_we_o  <= 1'b0;
`ifdef VGA_CFG_READBACK_EN
                  state_q   <= (idx_q inside {[3'd1:3'd4]}) ? StRdbk : StNext;
`else
                  state_q   <= StNext;
`endif
               end else if (wbs_err_i || tmo_hit) begin
                  wbs_stb_o <= 1'b0;
                  wbs_cyc_o <= 1'b0;
                  if (can_retry) begin
                     retry_q <= retry_q + 8'd1;
                     state_q <= StIssue;
                  end else begin
                     busy    <= 1'b0;
                     error   <= 1'b1;
                     err_idx <= idx_q;
                     state_q <= StFail;
                  end
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
`ifdef VGA_CFG_READBACK_EN
            StRdbk: begin
               // Address and write data stay latched; the data is the compare reference.
               wbs_we_o  <= 1'b0;
               wbs_stb_o <= 1'b1;
               wbs_cyc_o <= 1'b1;
               tmo_q     <= '0;
               state_q   <= StRwait;
            end
            StRwait: begin
               if (wbs_ack_i && (wbs_dat_i == wbs_dat_o)) begin
                  wbs_stb_o <= 1'b0;
                  wbs_cyc_o <= 1'b0;
                  state_q   <= StNext;
               end else if (wbs_ack_i || wbs_err_i || tmo_hit) begin
                  wbs_stb_o <= 1'b0;
                  wbs_cyc_o <= 1'b0;
                  if (can_retry) begin
                     retry_q <= retry_q + 8'd1;
                     state_q <= StIssue;
                  end else begin
                     busy    <= 1'b0;
                     error   <= 1'b1;
                     err_idx <= idx_q;
                     state_q <= StFail;
                  end
               end else begin
                  tmo_q <= tmo_q + 16'd1;
               end
            end
`endif
            StNext: begin
               if (idx_q == 3'd5) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q   <= idx_q + 3'd1;
                  retry_q <= '0;
                  state_q <= StIssue;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_cfg_seq.sv
// Bench for vga_cfg_seq: behavioural Wishbone slave with scripted responses and a
// program-level reference model predicting every bus transaction, its length and the run status.
module tb_vga_cfg_seq;

   localparam int unsigned ADR_W  = 12;
   localparam int unsigned T_TMO  = 4;
   localparam int unsigned T_RETR = 1;
   localparam logic [1:0]  T_CD   = 2'b00;
   localparam logic [1:0]  T_VBL  = 2'b11;
   localparam logic        T_PC   = 1'b0;
   localparam logic        T_HPOL = 1'b1;
   localparam logic        T_VPOL = 1'b1;
   localparam logic        T_CPOL = 1'b0;
   localparam logic        T_BPOL = 1'b0;
   localparam logic [1:0]  T_ODF  = 2'b00;

   logic             wb_clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       mode_sel = '0;
   logic [31:0]      vbara_i = '0;
   logic             busy, done, error;
   logic [2:0]       err_idx;
   logic [ADR_W-1:0] wbs_adr_o;
   logic [31:0]      wbs_dat_o;
   logic [31:0]      wbs_dat_i = '0;
   logic [3:0]       wbs_sel_o;
   logic             wbs_we_o, wbs_stb_o, wbs_cyc_o;
   logic             wbs_ack_i = 1'b0;
   logic             wbs_err_i = 1'b0;

   always #5 wb_clk = ~wb_clk;

   vga_cfg_seq #(
      .ADR_W(ADR_W), .TIMEOUT_CYC(T_TMO), .RETRIES(T_RETR), .CD(T_CD), .VBL(T_VBL),
      .PC(T_PC), .HPOL(T_HPOL), .VPOL(T_VPOL), .CPOL(T_CPOL), .BPOL(T_BPOL), .DVI_ODF(T_ODF)
   ) dut (
      .wb_clk(wb_clk), .reset(reset), .start(start), .mode_sel(mode_sel), .vbara_i(vbara_i),
      .busy(busy), .done(done), .error(error), .err_idx(err_idx),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i),
      .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o), .wbs_stb_o(wbs_stb_o),
      .wbs_cyc_o(wbs_cyc_o), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i)
   );

   // Slave reply per transaction: ack, err, silence, ack+err, ack with corrupted read data.
   typedef enum int {RspAck, RspErr, RspNone, RspBoth, RspBad} rsp_e;
   typedef struct {
      logic [ADR_W-1:0] adr;
      logic [31:0]      dat;
      logic             we;
      int               cyc;
   } txn_t;
   typedef struct {
      string       nm;
      int          mode;
      logic [31:0] vb;
      int          lat;
      int          poke;
      int          np;
      rsp_e        plan[6];
   } vec_t;

   rsp_e        rsp_q[$];
   rsp_e        plan_q[$];
   txn_t        log_q[$];
   txn_t        exp_q[$];
   logic [31:0] mem [int];
   int          ack_lat = 1;
   int          vectors = 0;
   int          errors = 0;

   bit          in_txn = 1'b0;
   int          scnt = 0;
   rsp_e        cur = RspAck;
   txn_t        cur_t;

   always @(negedge wb_clk) begin
      if (wbs_stb_o) begin
         if (!in_txn) begin
            in_txn = 1'b1;
            scnt = 0;
            cur = RspAck;
            if (rsp_q.size() != 0) cur = rsp_q.pop_front();
            cur_t.adr = wbs_adr_o;
            cur_t.dat = wbs_dat_o;
            cur_t.we  = wbs_we_o;
         end
         scnt++;
         if (scnt == ack_lat) begin
            if (cur == RspErr || cur == RspBoth) wbs_err_i = 1'b1;
            if (cur != RspErr && cur != RspNone) begin
               wbs_ack_i = 1'b1;
               if (wbs_we_o) mem[int'(wbs_adr_o)] = wbs_dat_o;
               else begin
                  wbs_dat_i = mem.exists(int'(wbs_adr_o)) ? mem[int'(wbs_adr_o)] : 32'h0;
                  if (cur == RspBad) wbs_dat_i = wbs_dat_i ^ 32'h0000_0100;
               end
            end
         end
      end else if (in_txn) begin
         in_txn = 1'b0;
         wbs_ack_i = 1'b0;
         wbs_err_i = 1'b0;
         cur_t.cyc = scnt;
         log_q.push_back(cur_t);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] prog_word(int idx, int mode, logic [31:0] vb);
      int hs[3] = '{95, 127, 135};
      int hg[3] = '{39, 87, 159};
      int ht[3] = '{639, 799, 1023};
      int hl[3] = '{799, 1055, 1343};
      int vs[3] = '{1, 3, 5};
      int vg[3] = '{24, 22, 28};
      int vt[3] = '{479, 599, 767};
      int vl[3] = '{524, 627, 805};
      case (idx)
         1: return vb;
         2: return (32'(hs[mode]) << 24) | (32'(hg[mode]) << 16) | 32'(ht[mode]);
         3: return (32'(vs[mode]) << 24) | (32'(vg[mode]) << 16) | 32'(vt[mode]);
         4: return (32'(hl[mode]) << 16) | 32'(vl[mode]);
         5: return (32'(T_ODF) << 28) | (32'(T_BPOL) << 15) | (32'(T_CPOL) << 14)
                 | (32'(T_VPOL) << 13) | (32'(T_HPOL) << 12) | (32'(T_PC) << 11)
                 | (32'(T_CD) << 9) | (32'(T_VBL) << 7) | 32'h1;
         default: return 32'h0;
      endcase
   endfunction

   // Walks the register program against the response plan; total cycles counted from the
   // edge that accepts start to the edge that raises done/error.
   task automatic model(input int mode, input logic [31:0] vb, input int lat,
                        output bit ok, output int fidx, output int cyc);
      int   adr_of[6] = '{0, 'h14, 'h08, 'h0C, 'h10, 0};
      rsp_e pq[$];
      rsp_e r;
      txn_t t;
      int   tries;
      bit   good;
      pq = plan_q;
      exp_q.delete();
      ok = 1'b0;
      fidx = 0;
      cyc = 1;
      if (mode == 3) return;
      for (int i = 0; i < 6; i++) begin
         tries = 0;
         while (1) begin
            r = RspAck;
            if (pq.size() != 0) r = pq.pop_front();
            t.adr = ADR_W'(adr_of[i]);
            t.dat = prog_word(i, mode, vb);
            t.we  = 1'b1;
            t.cyc = (r == RspNone) ? int'(T_TMO) : lat;
            exp_q.push_back(t);
            cyc += 1 + t.cyc;
            good = (r != RspErr && r != RspNone);
`ifdef VGA_CFG_READBACK_EN
            if (good && i >= 1 && i <= 4) begin
               r = RspAck;
               if (pq.size() != 0) r = pq.pop_front();
               t.we  = 1'b0;
               t.cyc = (r == RspNone) ? int'(T_TMO) : lat;
               exp_q.push_back(t);
               cyc += 1 + t.cyc;
               good = (r == RspAck || r == RspBoth);
            end
`endif
            if (good) break;
            if (tries < int'(T_RETR)) tries++;
            else begin
               fidx = i;
               return;
            end
         end
         cyc += 1;
      end
      ok = 1'b1;
   endtask

   function automatic int n_wr(int adr);
      int n = 0;
      foreach (log_q[i]) if (log_q[i].we && int'(log_q[i].adr) == adr) n++;
      return n;
   endfunction

   function automatic logic [31:0] last_wr(int adr);
      logic [31:0] d = 32'hDEAD_BEEF;
      foreach (log_q[i]) if (log_q[i].we && int'(log_q[i].adr) == adr) d = log_q[i].dat;
      return d;
   endfunction

   task automatic run(input string nm, input int mode, input logic [31:0] vb, input int lat,
                      input int poke, output int cycles);
      bit ok;
      int fidx, ecyc;
      bit busy_ok = 1'b1;
      ack_lat = lat;
      model(mode, vb, lat, ok, fidx, ecyc);
      rsp_q = plan_q;
      log_q.delete();
      @(negedge wb_clk);
      mode_sel = 2'(mode);
      vbara_i = vb;
      start = 1'b1;
      @(negedge wb_clk);
      start = 1'b0;
      cycles = 1;
      while (!(done || error) && cycles < 2000) begin
         if (!busy) busy_ok = 1'b0;
         if (cycles == poke) begin
            start = 1'b1;
            mode_sel = 2'd3;
            vbara_i = ~vb;
         end else start = 1'b0;
         @(negedge wb_clk);
         cycles++;
      end
      start = 1'b0;
      chk($sformatf("%s finished", nm), 32'(cycles < 2000), 32'd1);
      chk($sformatf("%s cycles", nm), 32'(cycles), 32'(ecyc));
      chk($sformatf("%s busy_during", nm), 32'(busy_ok), 32'd1);
      chk($sformatf("%s busy_end", nm), 32'(busy), 32'd0);
      chk($sformatf("%s done", nm), 32'(done), 32'(ok));
      chk($sformatf("%s error", nm), 32'(error), 32'(!ok));
      chk($sformatf("%s err_idx", nm), 32'(err_idx), 32'(ok ? 0 : fidx));
      @(negedge wb_clk);
      chk($sformatf("%s n_txn", nm), 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk($sformatf("%s t%0d adr", nm, i), 32'(log_q[i].adr), 32'(exp_q[i].adr));
         chk($sformatf("%s t%0d we", nm, i), 32'(log_q[i].we), 32'(exp_q[i].we));
         chk($sformatf("%s t%0d len", nm, i), 32'(log_q[i].cyc), 32'(exp_q[i].cyc));
         if (exp_q[i].we) chk($sformatf("%s t%0d dat", nm, i), log_q[i].dat, exp_q[i].dat);
      end
      rsp_q.delete();
   endtask

   task automatic chk_reset_vals(input string nm);
      chk($sformatf("%s stb", nm), 32'(wbs_stb_o), 32'd0);
      chk($sformatf("%s cyc", nm), 32'(wbs_cyc_o), 32'd0);
      chk($sformatf("%s we", nm), 32'(wbs_we_o), 32'd0);
      chk($sformatf("%s adr", nm), 32'(wbs_adr_o), 32'd0);
      chk($sformatf("%s dat", nm), wbs_dat_o, 32'd0);
      chk($sformatf("%s sel", nm), 32'(wbs_sel_o), 32'hF);
      chk($sformatf("%s status", nm), {28'd0, busy, done, error, 1'b0} | 32'(err_idx), 32'd0);
   endtask

   vec_t tbl[10];
   int   cyc_n;

   initial begin
      tbl[0] = '{"m0_lat1", 0, 32'h0003_C000, 1, 0, 0,
                 '{RspAck, RspAck, RspAck, RspAck, RspAck, RspAck}};
      tbl[1] = '{"m1_lat2", 1, 32'h1234_5000, 2, 0, 0,
                 '{RspAck, RspAck, RspAck, RspAck, RspAck, RspAck}};
      tbl[2] = '{"m2_err_retry", 2, 32'h0008_0000, 1, 0, 4,
                 '{RspAck, RspAck, RspErr, RspAck, RspAck, RspAck}};
      tbl[3] = '{"m2_err_twice", 2, 32'h0008_0000, 1, 0, 4,
                 '{RspAck, RspAck, RspErr, RspErr, RspAck, RspAck}};
      tbl[4] = '{"m0_timeout", 0, 32'h0000_1000, 1, 0, 2,
                 '{RspNone, RspNone, RspAck, RspAck, RspAck, RspAck}};
      tbl[5] = '{"m1_tmo_then_ack", 1, 32'hCAFE_0000, 3, 0, 3,
                 '{RspAck, RspNone, RspAck, RspAck, RspAck, RspAck}};
      tbl[6] = '{"mode3", 3, 32'h0000_0000, 1, 0, 0,
                 '{RspAck, RspAck, RspAck, RspAck, RspAck, RspAck}};
      tbl[7] = '{"busy_poke", 1, 32'h0001_2000, 1, 5, 0,
                 '{RspAck, RspAck, RspAck, RspAck, RspAck, RspAck}};
      tbl[8] = '{"ack_err_both", 2, 32'h0004_4000, 2, 0, 2,
                 '{RspBoth, RspBoth, RspAck, RspAck, RspAck, RspAck}};
      tbl[9] = '{"rerun_new_vb", 0, 32'h00AB_C000, 1, 0, 0,
                 '{RspAck, RspAck, RspAck, RspAck, RspAck, RspAck}};

      repeat (3) @(negedge wb_clk);
      chk_reset_vals("reset");
      reset = 1'b0;

      for (int v = 0; v < 10; v++) begin
         plan_q.delete();
         for (int k = 0; k < tbl[v].np; k++) plan_q.push_back(tbl[v].plan[k]);
         run(tbl[v].nm, tbl[v].mode, tbl[v].vb, tbl[v].lat, tbl[v].poke, cyc_n);
         if (v == 0) begin
            chk("m0 VBARA", last_wr('h14), 32'h0003_C000);
            chk("m0 HTIM", last_wr('h08), 32'h5F27_027F);
            chk("m0 CTRL", last_wr('h00), 32'h0000_3181);
`ifndef VGA_CFG_READBACK_EN
            chk("m0 run_len", 32'(cyc_n), 32'd19);
`endif
         end
         if (v == 1) begin
            chk("m1 HVLEN", last_wr('h10), 32'h041F_0273);
            chk("m1 VTIM", last_wr('h0C), 32'h0316_0257);
         end
`ifndef VGA_CFG_READBACK_EN
         if (v == 2) chk("m2 htim_writes", 32'(n_wr('h08)), 32'd2);
         if (v == 3) chk("m2 vtim_writes", 32'(n_wr('h0C)), 32'd0);
`endif
         if (v == 9) chk("rerun VBARA", last_wr('h14), 32'h00AB_C000);
      end

      // Reset while a write waits for an ack that never comes.
      plan_q.delete();
      rsp_q.push_back(RspNone);
      @(negedge wb_clk);
      mode_sel = 2'd0;
      start = 1'b1;
      @(negedge wb_clk);
      start = 1'b0;
      for (int k = 0; k < 50 && !wbs_stb_o; k++) @(negedge wb_clk);
      chk("rst_mid stb_seen", 32'(wbs_stb_o), 32'd1);
      @(negedge wb_clk);
      reset = 1'b1;
      @(negedge wb_clk);
      chk_reset_vals("rst_mid");
      reset = 1'b0;
      @(negedge wb_clk);
      rsp_q.delete();
      log_q.delete();

`ifdef VGA_CFG_READBACK_EN
      plan_q.delete();
      plan_q.push_back(RspAck);
      plan_q.push_back(RspAck);
      plan_q.push_back(RspBad);
      run("rdbk_bad_once", 0, 32'h0003_C000, 1, 0, cyc_n);
      chk("rdbk vbara_writes", 32'(n_wr('h14)), 32'd2);
      begin
         int nrd = 0;
         bit rd_ctrl = 1'b0;
         foreach (log_q[i]) if (!log_q[i].we) begin
            nrd++;
            if (log_q[i].adr == '0) rd_ctrl = 1'b1;
         end
         chk("rdbk reads", 32'(nrd), 32'd5);
         chk("rdbk no_ctrl_read", 32'(rd_ctrl), 32'd0);
      end
`endif

      for (int n = 0; n < 25; n++) begin
         int np, mode, poke;
         plan_q.delete();
         np = $urandom_range(0, 5);
         for (int k = 0; k < np; k++) begin
            int r = $urandom_range(0, 9);
            plan_q.push_back(r <= 5 ? RspAck : r == 6 ? RspErr : r == 7 ? RspNone :
                             r == 8 ? RspBoth : RspBad);
         end
         mode = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         poke = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 10);
         run($sformatf("rnd%0d", n), mode, $urandom, $urandom_range(1, 3), poke, cyc_n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
